eprisc_iobus_master: RTL
========================

// Module: eprisc_iobus_master
// PURPOSE
//  Host-side master for the 8-bit I/O-controller bus. Turns a 32-bit request {write, addr[14:0], data[15:0]}
//  into 6-phase frames (Load, B0..B3, Store); generates bus clock/select; captures read data from MISO.
//  Sits between the CPU's I/O port logic and the I/O controller board connector.
// PARAMETERS
//  CLK_DIV    2      iClk cycles per bus-clock half period (>=1)
//  SLAVE_SEL  2'b01  select code driven while bus is active (2'b00 = slave held in reset)
//  HOLD_CYC   8      iClk cycles select held at 2'b00 after iRst release
// PORTS
//  iClk         in   1   system clock; sole clock domain
//  iRst         in   1   asynchronous, active-high reset
//  iReqValid    in   1   request strobe
//  oReqReady    out  1   high only in IDLE; accept = iReqValid & oReqReady
//  iReqWrite    in   1   1 = write, 0 = read
//  iReqAddr     in   15  controller register address
//  iReqData     in   16  write data (ignored for reads)
//  oRspValid    out  1   one-cycle completion pulse, every request, no backpressure
//  oRspData     out  32  read word; 0 for writes; held until next accept
//  oIrq         out  1   interrupt to CPU
//  iIrqAck      in   1   clears latched interrupt (IOBUS_IRQ_LATCH_EN only)
//  oBusClock    out  1   bus clock; idles low
//  oBusSelect   out  2   2'b00 during reset/hold, else SLAVE_SEL
//  oBusMOSI     out  8   byte to slave
//  iBusMISO     in   8   byte from slave
//  iBusInterrupt in  1   async interrupt from slave
// BEHAVIOUR
//  Reset (async): oBusClock=0, oBusSelect=2'b00, oBusMOSI=0, oReqReady=0, oRspValid=0, oRspData=0, oIrq=0, FSM=HOLD.
//  Frame word W={iReqWrite,iReqAddr,iReqData}; B0=W[7:0], B1=W[15:8], B2=W[23:16], B3=W[31:24].
//  Bus clock runs only inside frames: 6 full periods per frame, rises r1..r6. Each half period = CLK_DIV iClk.
//  On the iClk edge producing rise rk: oBusMOSI <= B(k-1) for k=1..4, else 0; MISO sampled on same edge
//   (captures the byte driven in the phase just ending): r2->[7:0], r3->[15:8], r4->[23:16], r5->[31:24].
//  Slave commits writes at r6; after r6 slave is back in Load and clock parks low.
//  FSM: HOLD -(HOLD_CYC elapsed; select<=SLAVE_SEL)-> IDLE -(accept)-> CMD -(r6 fall done)->
//       write: RESP; read: FETCH (repeat frame, W[31]=0, same addr/data) -> RESP -> IDLE.
//  Reads need 2 frames so address is stable while MISO is driven; only FETCH-frame samples go to oRspData.
//  RESP: oRspValid=1 one cycle. Latency accept->oRspValid: write 12*CLK_DIV+1, read 24*CLK_DIV+1 iClk.
//  iReqValid while not IDLE: ignored (not queued). Accept captures fields; later input changes ignored.
//  Write to addr 15'h7FFF: issued as normal write (slave soft-resets peripherals); no special master action.
//  iRst mid-frame: frame aborted, select drops to 00 immediately (slave async reset), no oRspValid; HOLD reruns.
//  Divider counter wraps at CLK_DIV-1; CLK_DIV=1 gives bus clock = iClk/2.
// CONFIGURATION
//  IOBUS_IRQ_LATCH_EN defined: iBusInterrupt 2-flop synced; rising edge sets sticky oIrq; iIrqAck clears;
//   ack and new edge same cycle -> oIrq stays 1.
//  Not defined: oIrq = 2-flop synced level of iBusInterrupt; iIrqAck unused.
// STRUCTURE
//  Shared header iobus_defs.vh: frame phase codes, FRAME_RISES=6, W field positions (WR=31, ADDR=30:16,
//   DATA=15:0), SOFT_RESET_ADDR=15'h7FFF, default SLAVE_SEL.
//  Sub-module eprisc_iobus_clkgen: divider; gated clock out plus rise/fall strobes and rise counter.
// TESTING (bench includes behavioural controller model with identical 6-phase slave)
//  Reset: iRst 1 -> all outputs 0, select 00 for HOLD_CYC after release, then 01 and oReqReady=1.
//  Write addr 15'h0012 data 16'hBEEF -> MOSI EF,BE,12,00 on r1..r4; model reg 0x12=BEEF; oRspValid at 25 cycles (CLK_DIV=2).
//  Read addr 15'h0034 (model RAM=32'hCAFE1234) -> two frames, oRspData=32'hCAFE1234 at cycle 49.
//  Back-to-back: iReqValid held through write then read -> second accepted only after RESP; no overlap.
//  iRst asserted at r3 of read -> select 00 same cycle, no oRspValid; post-hold read returns correct data.
//  Interrupt: pulse iBusInterrupt 3 cycles -> latch build oIrq sticky until iIrqAck; level build oIrq follows +2 cycles.

Source files
------------

// File: rtl/eprisc_iobus_master_pkg.sv
// Shared definitions for the eprisc I/O-bus master: FSM states, frame phases,
// frame-word field positions and helpers for building and slicing frame words.
package eprisc_iobus_master_pkg;

    // Master sequencing states
    typedef enum logic [2:0] {
        ST_HOLD,
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_RESP
    } state_t;

    // Slave-side phase of a frame; rise k (1-based) ends the phase (k-1)
    typedef enum logic [2:0] {
        PH_LOAD,
        PH_B0,
        PH_B1,
        PH_B2,
        PH_B3,
        PH_STORE
    } phase_t;

    // Bus-clock rising edges per frame
    localparam int FRAME_RISES = 6;

    // Frame word field positions: {write, addr[14:0], data[15:0]}
    localparam int W_WR       = 31;
    localparam int W_ADDR_MSB = 30;
    localparam int W_ADDR_LSB = 16;
    localparam int W_DATA_MSB = 15;
    localparam int W_DATA_LSB = 0;

    // Select code for an active slave; writes to address 15'h7FFF soft-reset the
    // slave's peripherals but are sent as ordinary writes by the master
    localparam logic [1:0] DEFAULT_SLAVE_SEL = 2'b01;

    function automatic logic [31:0] make_word(input logic wr,
                                              input logic [14:0] addr,
                                              input logic [15:0] data);
        logic [31:0] w;
        w = '0;
        w[W_WR] = wr;
        w[W_ADDR_MSB:W_ADDR_LSB] = addr;
        w[W_DATA_MSB:W_DATA_LSB] = data;
        return w;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eprisc_iobus_clkgen.sv
// Bus clock generator: divides iClk into a gated bus clock that only runs while
// 'run' is high, with rise/fall strobes for the edge that produces each
// transition and a rise index (0-based) within the current frame.
module eprisc_iobus_clkgen
    import eprisc_iobus_master_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       bus_clk,
    output logic       rise_stb,
    output logic       fall_stb,
    output logic [2:0] rise_idx
);

    localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]        HALF_LAST = 4'(2 * FRAME_RISES - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       half_cnt;
    logic             tick;

    assign tick     = run && (div_cnt == DIV_LAST);
    assign rise_stb = tick && !bus_clk;
    assign fall_stb = tick && bus_clk;
    assign rise_idx = half_cnt[3:1];

    // Divider and half-period counter; everything parks at zero/low between frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            bus_clk  <= 1'b0;
        end else if (!run) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            bus_clk  <= 1'b0;
        end else if (tick) begin
            div_cnt  <= '0;
            bus_clk  <= ~bus_clk;
            half_cnt <= (half_cnt == HALF_LAST) ? 4'd0 : half_cnt + 4'd1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/eprisc_iobus_master.sv
// Host-side master for the 8-bit I/O-controller bus. Converts a request into one
// (write) or two (read: command + fetch) 6-phase frames and returns a response.
// Build option: define IOBUS_IRQ_LATCH_EN for a sticky, ack-cleared interrupt;
// otherwise oIrq is the synchronised level of iBusInterrupt.
module eprisc_iobus_master
    import eprisc_iobus_master_pkg::*;
#(
    parameter int         CLK_DIV   = 2,
    parameter logic [1:0] SLAVE_SEL = DEFAULT_SLAVE_SEL,
    parameter int         HOLD_CYC  = 8
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWrite,
    input  logic [14:0] iReqAddr,
    input  logic [15:0] iReqData,
    output logic        oRspValid,
    output logic [31:0] oRspData,
    output logic        oIrq,
    input  logic        iIrqAck,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO,
    input  logic        iBusInterrupt
);

    // HOLD_CYC is expected to be at least 1
    localparam int              HC_W      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [HC_W-1:0] hold_cnt;
    logic        hold_done;
    logic        run;
    logic        accept;
    logic        frame_done;
    logic        req_write;
    logic [14:0] req_addr;
    logic [15:0] req_data;
    logic [31:0] frame_word;
    logic [31:0] rd_word;
    logic        rise_stb;
    logic        fall_stb;
    logic [2:0]  rise_idx;

    eprisc_iobus_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (iClk),
        .rst      (iRst),
        .run      (run),
        .bus_clk  (oBusClock),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .rise_idx (rise_idx)
    );

    assign hold_done  = (hold_cnt == HOLD_LAST);
    assign frame_done = fall_stb && (rise_idx == 3'(FRAME_RISES - 1));
    // The fetch frame repeats the command as a read so the address stays put
    assign frame_word = make_word(req_write && (state_q != ST_FETCH), req_addr, req_data);

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state_q <= ST_HOLD;
        else      state_q <= state_d;
    end

    // Next-state and handshake decode
    always_comb begin
        state_d   = state_q;
        oReqReady = 1'b0;
        run       = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_HOLD:  if (hold_done) state_d = ST_IDLE;
            ST_IDLE: begin
                oReqReady = 1'b1;
                if (iReqValid) begin
                    accept  = 1'b1;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                run = 1'b1;
                if (frame_done) state_d = req_write ? ST_RESP : ST_FETCH;
            end
            ST_FETCH: begin
                run = 1'b1;
                if (frame_done) state_d = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_HOLD;
        endcase
    end

    // Post-reset hold timer and bus select; select stays 00 until the hold elapses
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hold_cnt   <= '0;
            oBusSelect <= 2'b00;
        end else if (state_q == ST_HOLD) begin
            if (hold_done) oBusSelect <= SLAVE_SEL;
            else           hold_cnt   <= hold_cnt + 1'b1;
        end
    end

    // Request fields are frozen at accept; later input changes are ignored
    always_ff @(posedge iClk) begin
        if (accept) begin
            req_write <= iReqWrite;
            req_addr  <= iReqAddr;
            req_data  <= iReqData;
        end
    end

    // MOSI byte launched on the edge producing each rise: B0..B3 on r1..r4, then 0
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oBusMOSI <= 8'h00;
        end else if (rise_stb) begin
            if (rise_idx < 3'd4) oBusMOSI <= frame_byte(frame_word, rise_idx[1:0]);
            else                 oBusMOSI <= 8'h00;
        end
    end

    // Read capture: r2..r5 of the fetch frame sample the byte of the phase just ending
    always_ff @(posedge iClk) begin
        if (rise_stb && (state_q == ST_FETCH)) begin
            case (rise_idx)
                3'd1:    rd_word[7:0]   <= iBusMISO;
                3'd2:    rd_word[15:8]  <= iBusMISO;
                3'd3:    rd_word[23:16] <= iBusMISO;
                3'd4:    rd_word[31:24] <= iBusMISO;
                default: ;
            endcase
        end
    end

    // Completion pulse and response word; writes return zero
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oRspValid <= 1'b0;
            oRspData  <= '0;
        end else begin
            oRspValid <= (state_q == ST_RESP);
            if (state_q == ST_RESP) oRspData <= req_write ? 32'h0 : rd_word;
        end
    end

`ifdef IOBUS_IRQ_LATCH_EN
    logic irq_s1, irq_s2, irq_s3;

    // Synchronise the slave interrupt; a rising edge sets oIrq, ack clears, set wins
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            irq_s1 <= 1'b0;
            irq_s2 <= 1'b0;
            irq_s3 <= 1'b0;
            oIrq   <= 1'b0;
        end else begin
            irq_s1 <= iBusInterrupt;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
            if (irq_s2 && !irq_s3) oIrq <= 1'b1;
            else if (iIrqAck)      oIrq <= 1'b0;
        end
    end
`else
    logic irq_s1, irq_s2;
    logic unused_ack;

    assign unused_ack = iIrqAck;
    assign oIrq       = irq_s2;

    // Two-flop synchroniser; oIrq follows the slave interrupt level
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            irq_s1 <= 1'b0;
            irq_s2 <= 1'b0;
        end else begin
            irq_s1 <= iBusInterrupt;
            irq_s2 <= irq_s1;
        end
    end
`endif

endmodule
